mem_block_copy: RTL

Initiator-side memory master that copies a block of 31-bit words from one 12-bit word address range to another over the single-port memory request/finish interface. It sits between the control unit (start/busy/done) and the main memory block, issuing one read then one write per word. Use it for the block-move and program-relocation operations, so the CPU datapath does not sequence them word by word.

---
 rtl/mem_block_copy.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_block_copy.sv
// mem_block_copy: memory master that copies a block of 31-bit words between
// two 12-bit word address ranges, one read followed by one write per word.
// All memory request outputs are registered; the controller waits as long as
// needed for mem_finish on each access.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands latched on accepted start
// RD    | read request to src held until mem_finish
// WR    | write request to dst held until mem_finish
// DONE  | one-cycle done pulse, then back to IDLE
module mem_block_copy (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [11:0] src_addr,
  input  logic [11:0] dst_addr,
  input  logic [11:0] count,
  output logic        busy,
  output logic        done,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [11:0] mem_addr,
  output logic [30:0] mem_write_data,
  input  logic [30:0] mem_read_data,
  input  logic        mem_finish
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state;
  logic [11:0] src_q;
  logic [11:0] dst_q;
  logic [11:0] rem_q;

  // Sequencer: state, address/remaining counters and registered request outputs.
  // mem_write_data doubles as the data register holding the word just read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      src_q            <= 12'd0;
      dst_q            <= 12'd0;
      rem_q            <= 12'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr         <= 12'd0;
      mem_write_data   <= 31'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            rem_q <= count;
            if (count == 12'd0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state           <= ST_RD;
              busy            <= 1'b1;
              mem_read_enable <= 1'b1;
              mem_addr        <= src_addr;
            end
          end
        end
        ST_RD: begin
          if (mem_finish) begin
            mem_write_data   <= mem_read_data;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b1;
            mem_addr         <= dst_q;
            state            <= ST_WR;
          end
        end
        ST_WR: begin
          if (mem_finish) begin
            mem_write_enable <= 1'b0;
            src_q            <= src_q + 12'd1;
            dst_q            <= dst_q + 12'd1;
            rem_q            <= rem_q - 12'd1;
            if (rem_q == 12'd1) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // Address wraps naturally at 12 bits.
              state           <= ST_RD;
              mem_read_enable <= 1'b1;
              mem_addr        <= src_q + 12'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
